// File: rtl/tdm_mux_pkg.sv
// Shared types and constants for the TDM scan multiplexer.
package tdm_mux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } state_e;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Select width for n channels; a single channel bit is kept even for n <= 2.
    function automatic int sel_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tdm_scan_mux_dwell_counter.sv
// Dwell counter for scan mode: counts 0..DWELL-1 and flags the last cycle of a dwell.
module dwell_counter #(
    parameter  int DWELL = 4,
    localparam int CNTW  = (DWELL > 1) ? $clog2(DWELL) : 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNTW-1:0] cnt_q;
    logic [CNTW-1:0] cnt_d;

    // Terminal count is a decode of the register, so it is glitch-free per cycle.
    always_comb begin
        tc = (cnt_q == CNTW'(DWELL - 1));
    end

    // Next count: clear dominates, wrap on terminal count, hold when not enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (tc) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNTW'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tdm_scan_mux.sv
// Time-division channel multiplexer: manual channel select or automatic round-robin
// scan with a fixed dwell, feeding a single valid/ready output register.
module tdm_scan_mux
    import tdm_mux_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NCH   = 4,
    parameter  int DWELL = 4,
    localparam int SELW  = sel_width(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] data_in,
    input  logic [SELW-1:0]      sel,
    input  logic                 mode,
    input  logic                 enable,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    output logic                 out_valid
);

    state_e            state_q, state_d;
    logic [SELW-1:0]   ptr_q, ptr_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic [SELW-1:0]   out_ch_q, out_ch_d;
    logic              out_valid_q, out_valid_d;

    logic              stall_s;
    logic              capture_s;
    logic [SELW-1:0]   cap_idx_s;
    logic [WIDTH-1:0]  cap_data_s;
    logic              scan_clr_s;
    logic              scan_en_s;
    logic              tc_s;

    // Mode decode: evaluated every cycle, stalled or not.
    always_comb begin
        state_d = IDLE;
        if (!enable) begin
            state_d = IDLE;
        end else if (mode == MODE_SCAN) begin
            state_d = SCAN;
        end else begin
            state_d = MANUAL;
        end
    end

    // Capture decision and channel index for the current state.
    always_comb begin
        stall_s   = out_valid_q & ~out_ready;
        capture_s = 1'b0;
        cap_idx_s = ptr_q;
        case (state_q)
            MANUAL: begin
                capture_s = ~stall_s;
                cap_idx_s = sel;
            end
            SCAN: begin
                capture_s = ~stall_s & tc_s;
                cap_idx_s = ptr_q;
            end
            default: begin
                capture_s = 1'b0;
                cap_idx_s = ptr_q;
            end
        endcase
    end

    // Channel select from the flattened input bus.
    always_comb begin
        cap_data_s = '0;
        for (int k = 0; k < NCH; k++) begin
            if (cap_idx_s == SELW'(k)) begin
                cap_data_s = data_in[k*WIDTH +: WIDTH];
            end else begin
                cap_data_s = cap_data_s;
            end
        end
    end

    // Scan pointer and dwell counter stay cleared outside SCAN, so each entry starts at ch0, cnt=0.
    always_comb begin
        scan_clr_s = (state_q != SCAN);
        scan_en_s  = ~stall_s;
        if (scan_clr_s) begin
            ptr_d = '0;
        end else if (capture_s) begin
            ptr_d = ptr_q + SELW'(1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Output register: a capture overrides a same-cycle accept (back-to-back).
    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        if (capture_s) begin
            out_data_d  = cap_data_s;
            out_ch_d    = cap_idx_s;
            out_valid_d = 1'b1;
        end else begin
            out_valid_d = out_valid_q & ~out_ready;
        end
    end

    dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (scan_clr_s),
        .en    (scan_en_s),
        .tc    (tc_s)
    );

    // State, pointer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_tdm_scan_mux.sv
// Directed bench for tdm_scan_mux (WIDTH=8, NCH=4, DWELL=4; ch0..ch3 = 0x11..0x44).
module tb_tdm_scan_mux;

    logic        clk;
    logic        rst_n;
    logic [31:0] data_in;
    logic [1:0]  sel;
    logic        mode;
    logic        enable;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_valid;

    int n_cmp;
    int n_bad;

    tdm_scan_mux #(
        .WIDTH (8),
        .NCH   (4),
        .DWELL (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .sel       (sel),
        .mode      (mode),
        .enable    (enable),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cycle(input string tag, input logic v, input logic [7:0] d, input logic [1:0] c);
        tick();
        chk_value({tag, ".valid"}, 32'(out_valid), 32'(v));
        if (v) begin
            chk_value({tag, ".data"}, 32'(out_data), 32'(d));
            chk_value({tag, ".ch"}, 32'(out_ch), 32'(c));
        end
    endtask

    // Assert reset between edges and check the outputs clear before the next edge.
    task automatic pulse_rst(input string tag);
        #3;
        rst_n = 1'b0;
        #1;
        chk_value({tag, ".valid"}, 32'(out_valid), 32'h0);
        chk_value({tag, ".data"}, 32'(out_data), 32'h0);
        chk_value({tag, ".ch"}, 32'(out_ch), 32'h0);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        data_in   = 32'h4433_2211;
        sel       = 2'd0;
        mode      = 1'b0;
        enable    = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b0;

        // Reset state
        repeat (2) tick();
        chk_value("rst.valid", 32'(out_valid), 32'h0);
        chk_value("rst.data", 32'(out_data), 32'h0);
        chk_value("rst.ch", 32'(out_ch), 32'h0);
        rst_n = 1'b1;

        // Manual mode: one entry cycle, then sel 2,0,3 with 1-cycle latency
        enable = 1'b1;
        mode   = 1'b0;
        sel    = 2'd0;
        tick();
        sel = 2'd2;
        expect_cycle("man0", 1'b1, 8'h33, 2'd2);
        sel = 2'd0;
        expect_cycle("man1", 1'b1, 8'h11, 2'd0);
        sel = 2'd3;
        expect_cycle("man2", 1'b1, 8'h44, 2'd3);

        // Asynchronous reset mid-cycle
        enable = 1'b0;
        pulse_rst("arst");
        tick();

        // Scan with wrap: entry edge is tick 1, captures on ticks 5, 9, 13, 17, 21
        enable = 1'b1;
        mode   = 1'b1;
        for (int i = 1; i <= 21; i++) begin
            if (i >= 5 && ((i - 5) % 4) == 0) begin
                expect_cycle("scan", 1'b1, 8'(8'h11 * (((i - 5) / 4) % 4 + 1)), 2'(((i - 5) / 4) % 4));
            end else begin
                expect_cycle("scan", 1'b0, 8'h00, 2'd0);
            end
        end
        repeat (3) expect_cycle("scan.gap", 1'b0, 8'h00, 2'd0);
        expect_cycle("scan.s22", 1'b1, 8'h22, 2'd1);

        // Stall: 0x22 held for 6 cycles, then 0x33 three cycles after the accepting edge
        out_ready = 1'b0;
        repeat (6) expect_cycle("stall.hold", 1'b1, 8'h22, 2'd1);
        out_ready = 1'b1;
        repeat (3) expect_cycle("stall.rel", 1'b0, 8'h00, 2'd0);
        expect_cycle("stall.s33", 1'b1, 8'h33, 2'd2);
        repeat (3) expect_cycle("stall.gap", 1'b0, 8'h00, 2'd0);
        expect_cycle("stall.s44", 1'b1, 8'h44, 2'd3);
        repeat (3) expect_cycle("wrap.gap", 1'b0, 8'h00, 2'd0);
        expect_cycle("wrap.s11", 1'b1, 8'h11, 2'd0);
        repeat (3) expect_cycle("wrap.gap2", 1'b0, 8'h00, 2'd0);
        expect_cycle("wrap.s22", 1'b1, 8'h22, 2'd1);

        // Mode switch mid-dwell with ptr=2: SCAN -> MANUAL -> SCAN restarts at ch0
        repeat (2) expect_cycle("msw.dwell", 1'b0, 8'h00, 2'd0);
        mode = 1'b0;
        sel  = 2'd1;
        expect_cycle("msw.tomanual", 1'b0, 8'h00, 2'd0);
        expect_cycle("msw.man", 1'b1, 8'h22, 2'd1);
        mode = 1'b1;
        expect_cycle("msw.toscan", 1'b1, 8'h22, 2'd1);
        repeat (3) expect_cycle("msw.gap", 1'b0, 8'h00, 2'd0);
        expect_cycle("msw.s11", 1'b1, 8'h11, 2'd0);

        // Reset mid-stall: pending sample discarded, scan restarts at ch0
        out_ready = 1'b0;
        repeat (2) expect_cycle("rstall.hold", 1'b1, 8'h11, 2'd0);
        pulse_rst("rstall");
        repeat (4) expect_cycle("rstall.gap", 1'b0, 8'h00, 2'd0);
        expect_cycle("rstall.s11", 1'b1, 8'h11, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tdm_scan_mux.md
TDM_SCAN_MUX -- requirements
Module: tdm_scan_mux

Interface
REQ-001 Parameter WIDTH, default 8, bit width of each channel.
REQ-002 Parameter NCH, default 4, number of channels; power of two, at least 2.
REQ-003 Parameter DWELL, default 4, cycles spent on each channel in scan mode; at least 1.
REQ-004 Derived constant SELW = log2(NCH), at least 1.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 data_in  in  NCH*WIDTH  flattened channel bus; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-008 sel  in  SELW  channel select, used in manual mode only.
REQ-009 mode  in  1  0 = manual, 1 = auto-scan.
REQ-010 enable  in  1  sampling enable.
REQ-011 out_ready  in  1  downstream accepts the sample.
REQ-012 out_data  out  WIDTH  registered sample.
REQ-013 out_ch  out  SELW  channel index of out_data.
REQ-014 out_valid  out  1  out_data/out_ch hold a sample not yet accepted.

Function
REQ-015 Define stall = out_valid & ~out_ready; sampling (capture) occurs only when stall = 0.
REQ-016 FSM states: IDLE, MANUAL, SCAN.
- enable=0 -> IDLE.
- enable=1 & mode=0 -> MANUAL.
- enable=1 & mode=1 -> SCAN.
- Transitions are evaluated every cycle, including while stalled.
REQ-017 In IDLE there is no capture; a pending sample (out_valid=1) holds until accepted, after which out_valid=0.
REQ-018 In MANUAL, each non-stalled cycle captures data_in[sel] into out_data and sel into out_ch, with out_valid=1 on the next cycle; latency is 1 cycle.
REQ-019 SCAN has a channel pointer ptr (SELW bits) and a dwell counter cnt (0..DWELL-1).
- Both are cleared to 0 on every entry into SCAN.
- The entry cycle counts as cnt=0.
REQ-020 In SCAN, on each non-stalled cycle:
- if cnt = DWELL-1: capture data_in[ptr] (out_ch = ptr), set ptr = (ptr+1) mod NCH, set cnt = 0;
- otherwise cnt increments.
REQ-021 In SCAN, when stalled, cnt and ptr hold; no samples are dropped and no channel is skipped.
REQ-022 ptr wraps from NCH-1 to 0 with no idle cycle.
REQ-023 On a non-stalled cycle with no capture, out_valid becomes 0 if the prior sample was accepted; out_data/out_ch keep their last values.
REQ-024 Accept and capture in the same cycle (out_valid=1, out_ready=1, capture due) loads the new sample with out_valid staying 1 (back-to-back).
REQ-025 A mode or enable change while out_valid=1 never alters out_data/out_ch before acceptance.
REQ-026 If DWELL = 1, scan captures every non-stalled cycle.

Reset
REQ-027 rst_n low asynchronously forces state=IDLE, ptr=0, cnt=0, out_data=0, out_ch=0, out_valid=0.
REQ-028 Reset asserted mid-scan or mid-stall discards the pending sample; the first capture after release follows REQ-018/REQ-019 from a cleared state.
REQ-029 Release of rst_n is synchronous to clk; the first state update occurs on the first rising edge after release.

Structure
REQ-030 Shared package tdm_mux_pkg holds:
- the state enum (IDLE, MANUAL, SCAN);
- the mode constants MODE_MANUAL=0 and MODE_SCAN=1;
- the clog2-based SELW helper.
REQ-031 One sub-module, dwell_counter, holds cnt with clear/enable inputs, parameter DWELL, and a terminal-count output; channel selection, the FSM and the output register remain in tdm_scan_mux.

Verification (WIDTH=8, NCH=4, DWELL=4; data_in ch0..ch3 = 0x11, 0x22, 0x33, 0x44)
REQ-032 Reset: rst_n=0 asserted between edges -> outputs become 0 immediately, without waiting for a clock edge.
REQ-033 Manual: enable=1, mode=0, out_ready=1, sel stepped 2,0,3 -> out_data = 0x33, 0x11, 0x44 with out_ch = 2, 0, 3, each one cycle after its sel, with out_valid continuous.
REQ-034 Scan wrap: enable=1, mode=1, out_ready=1 for 20 cycles -> samples 0x11, 0x22, 0x33, 0x44, 0x11, one every 4 cycles, the first valid 4 cycles after entering SCAN.
REQ-035 Stall: in scan, hold out_ready=0 for 6 cycles after the 0x22 sample -> 0x22 is held stable, then 0x33 follows exactly 3 cycles after out_ready returns to 1; no channel is lost.
REQ-036 Mode switch: switch SCAN->MANUAL->SCAN mid-dwell (ptr=2) -> on re-entry, scan restarts at ch0 (0x11) after 4 cycles.
REQ-037 Reset mid-stall: pulse rst_n low while out_valid=1 and out_ready=0 -> out_valid=0; after release the scan restarts at ch0.
